// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the LSU stage: access-size encodings, FSM states and
// the writeback control width used by both the execute and writeback stages.
package lsu_stage_pkg;

    localparam int LSU_WB_CTRL_W = 8;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Byte accesses never fault; an unused size code is treated like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data replication and
// load-data extraction with sign or zero extension.
module lsu_align
    import lsu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_unsigned,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [3:0]       o_wstrb,
    output logic [WIDTH-1:0] o_wdata,
    output logic [WIDTH-1:0] o_ldata
);

    logic [WIDTH-1:0] w_shift;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_rs2;
        o_ldata = w_shift;
        case (i_size)
            MEM_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
                o_ldata = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
            end
            MEM_H: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_rs2[15:0]}};
                o_ldata = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// RV32 memory-access stage: issues loads/stores on a valid/ready bus and
// holds a one-entry registered result for writeback.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WB_CTRL_W = LSU_WB_CTRL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [WIDTH-1:0]     ex_alu_result,
    input  logic [WIDTH-1:0]     ex_rs2_data,
    input  logic [WIDTH-1:0]     ex_pc,
    input  logic [WIDTH-1:0]     ex_inst,
    input  logic                 ex_mem_ren,
    input  logic                 ex_mem_wen,
    input  logic [1:0]           ex_mem_size,
    input  logic                 ex_mem_unsigned,
    input  logic [WB_CTRL_W-1:0] ex_wb_ctrl,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_wen,
    output logic [WIDTH-1:0]     mem_req_addr,
    output logic [WIDTH-1:0]     mem_req_wdata,
    output logic [3:0]           mem_req_wstrb,
    input  logic                 mem_resp_valid,
    input  logic [WIDTH-1:0]     mem_resp_rdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [WIDTH-1:0]     wb_data,
    output logic [WIDTH-1:0]     wb_pc,
    output logic [WIDTH-1:0]     wb_inst,
    output logic [WB_CTRL_W-1:0] wb_ctrl,
    output logic                 wb_misalign
);

    lsu_state_e r_state, w_state_nxt;

    logic [WIDTH-1:0]     r_addr, r_rs2, r_pc, r_inst;
    logic [1:0]           r_size;
    logic                 r_uns, r_wen;
    logic [WB_CTRL_W-1:0] r_ctrl;

    logic                 r_wb_valid, r_wb_misalign;
    logic [WIDTH-1:0]     r_wb_data, r_wb_pc, r_wb_inst;
    logic [WB_CTRL_W-1:0] r_wb_ctrl;

    logic             w_accept, w_is_mem, w_misalign, w_issue, w_resp;
    logic [3:0]       w_wstrb;
    logic [WIDTH-1:0] w_wdata, w_ldata;

    assign w_accept   = ex_valid && ex_ready;
    assign w_is_mem   = ex_mem_ren || ex_mem_wen;
    assign w_misalign = is_misaligned(ex_mem_size, ex_alu_result[1:0]);
    assign w_issue    = w_accept && w_is_mem && !w_misalign;
    // Responses outside WAIT (e.g. left over from before a reset) are dropped.
    assign w_resp     = (r_state == WAIT) && mem_resp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        ex_ready      = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                ex_ready = !r_wb_valid || wb_ready;
                if (w_issue) w_state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_rs2  <= '0;
            r_pc   <= '0;
            r_inst <= '0;
            r_size <= '0;
            r_uns  <= 1'b0;
            r_wen  <= 1'b0;
            r_ctrl <= '0;
        end else if (w_issue) begin
            r_addr <= ex_alu_result;
            r_rs2  <= ex_rs2_data;
            r_pc   <= ex_pc;
            r_inst <= ex_inst;
            r_size <= ex_mem_size;
            r_uns  <= ex_mem_unsigned;
            r_wen  <= ex_mem_wen;
            r_ctrl <= ex_wb_ctrl;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_rs2      (r_rs2),
        .i_rdata    (mem_resp_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = {r_addr[WIDTH-1:2], 2'b00};
    assign mem_req_wdata = w_wdata;
    assign mem_req_wstrb = r_wen ? w_wstrb : 4'b0000;

    // A memory op is only accepted while the output register is free, so it
    // is always empty by the time the response lands in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
            r_wb_data     <= '0;
            r_wb_pc       <= '0;
            r_wb_inst     <= '0;
            r_wb_ctrl     <= '0;
        end else if (w_accept && (!w_is_mem || w_misalign)) begin
            r_wb_valid    <= 1'b1;
            r_wb_misalign <= w_is_mem;
            r_wb_data     <= w_is_mem ? '0 : ex_alu_result;
            r_wb_pc       <= ex_pc;
            r_wb_inst     <= ex_inst;
            r_wb_ctrl     <= ex_wb_ctrl;
        end else if (w_resp) begin
            r_wb_valid    <= 1'b1;
            r_wb_misalign <= 1'b0;
            r_wb_data     <= r_wen ? r_addr : w_ldata;
            r_wb_pc       <= r_pc;
            r_wb_inst     <= r_inst;
            r_wb_ctrl     <= r_ctrl;
        end else if (r_wb_valid && wb_ready) begin
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_misalign = r_wb_misalign;
    assign wb_data     = r_wb_data;
    assign wb_pc       = r_wb_pc;
    assign wb_inst     = r_wb_inst;
    assign wb_ctrl     = r_wb_ctrl;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases plus randomized ops scored
// against a byte-lane arithmetic model of the memory stage.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_result, ex_rs2_data, ex_pc, ex_inst;
    logic        ex_mem_ren, ex_mem_wen, ex_mem_unsigned;
    logic [1:0]  ex_mem_size;
    logic [7:0]  ex_wb_ctrl;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        wb_valid, wb_ready, wb_misalign;
    logic [31:0] wb_data, wb_pc, wb_inst;
    logic [7:0]  wb_ctrl;

    int n_cmp = 0;
    int n_err = 0;

    lsu_stage #(.WIDTH(32), .WB_CTRL_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_pc(ex_pc), .ex_inst(ex_inst),
        .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .ex_wb_ctrl(ex_wb_ctrl),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_ctrl(wb_ctrl),
        .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic logic m_misalign(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic wen, input logic [1:0] size, input logic [31:0] addr);
        int lo = int'(addr % 4);
        if (!wen) return 4'd0;
        if (size == 2'd0) return 4'(1 << lo);
        if (size == 2'd1) return 4'(3 << lo);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] rs2);
        if (size == 2'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    task automatic chk_req(input string tag, input logic wen, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] rs2);
        chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, ".req_addr"},  mem_req_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".req_wen"},   32'(mem_req_wen), 32'(wen));
        chk({tag, ".req_wstrb"}, 32'(mem_req_wstrb), 32'(m_wstrb(wen, size, addr)));
        if (wen) chk({tag, ".req_wdata"}, mem_req_wdata, m_wdata(size, rs2));
        chk({tag, ".ex_ready_busy"}, 32'(ex_ready), 32'd0);
    endtask

    // Starts at posedge+1 with wb_ready = 1; returns at posedge+1 after the
    // result has been checked and released.
    task automatic run_op(input string tag, input logic ren, input logic wen,
                          input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int req_stall, input int resp_dly);
        logic [31:0] pc, inst;
        logic [7:0]  ctrl;
        logic        mem, mis;
        pc = $urandom; inst = $urandom; ctrl = 8'($urandom);
        mem = ren | wen;
        mis = mem && m_misalign(size, addr);
        ex_valid = 1'b1; ex_alu_result = addr; ex_rs2_data = rs2; ex_pc = pc; ex_inst = inst;
        ex_mem_ren = ren; ex_mem_wen = wen; ex_mem_size = size; ex_mem_unsigned = uns;
        ex_wb_ctrl = ctrl;
        @(negedge clk);
        chk({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (!mem || mis) begin
            @(negedge clk);
            chk({tag, ".req_idle"}, 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i < req_stall; i++) begin
                @(negedge clk);
                chk_req({tag, ".stall"}, wen, size, addr, rs2);
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            chk_req(tag, wen, size, addr, rs2);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int i = 0; i < resp_dly; i++) begin
                @(negedge clk);
                chk({tag, ".wait_req"}, 32'(mem_req_valid), 32'd0);
                chk({tag, ".wait_wb"},  32'(wb_valid), 32'd0);
                @(posedge clk); #1;
            end
            mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
            @(negedge clk);
        end
        chk({tag, ".wb_valid"},    32'(wb_valid), 32'd1);
        chk({tag, ".wb_misalign"}, 32'(wb_misalign), 32'(mis));
        chk({tag, ".wb_data"}, wb_data,
            !mem ? addr : mis ? 32'd0 : wen ? addr : m_load(size, uns, addr, rdata));
        chk({tag, ".wb_pc"},   wb_pc, pc);
        chk({tag, ".wb_inst"}, wb_inst, inst);
        chk({tag, ".wb_ctrl"}, 32'(wb_ctrl), 32'(ctrl));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; wb_ready = 1'b0;
        ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0; ex_pc = '0; ex_inst = '0;
        ex_mem_ren = 1'b0; ex_mem_wen = 1'b0; ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0;
        ex_wb_ctrl = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        #12;
        chk("rst.wb_valid",    32'(wb_valid), 32'd0);
        chk("rst.wb_misalign", 32'(wb_misalign), 32'd0);
        chk("rst.req_valid",   32'(mem_req_valid), 32'd0);
        chk("rst.wb_data",     wb_data, 32'd0);
        chk("rst.wb_pc",       wb_pc, 32'd0);
        chk("rst.wb_inst",     wb_inst, 32'd0);
        chk("rst.wb_ctrl",     32'(wb_ctrl), 32'd0);
        chk("rst.ex_ready",    32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; wb_ready = 1'b1;

        // Back-to-back pass-through at full throughput.
        ex_valid = 1'b1; ex_alu_result = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            ex_pc = 32'(k * 4);
            @(negedge clk);
            chk("b2b.ex_ready", 32'(ex_ready), 32'd1);
            if (k > 0) begin
                chk("b2b.wb_data", wb_data, 32'h1234);
                chk("b2b.wb_pc",   wb_pc, 32'((k - 1) * 4));
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        @(negedge clk);
        chk("b2b.last_valid", 32'(wb_valid), 32'd1);
        chk("b2b.last_pc",    wb_pc, 32'd8);
        @(posedge clk); #1;

        run_op("lb",  1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lb.const", wb_data, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lbu.const", wb_data, 32'h0000_0080);
        run_op("sh",  0, 1, 2'd1, 0, 32'h2002, 32'hABCD_1234, 32'h0, 0, 0);
        chk("sh.const", wb_data, 32'h2002);
        run_op("sw_stall", 0, 1, 2'd2, 0, 32'h2F00, 32'hCAFE_F00D, 32'h0, 3, 2);
        run_op("lw_mis", 1, 0, 2'd2, 0, 32'h3001, 32'h0, 32'h0, 0, 0);
        chk("lw_mis.const", wb_data, 32'd0);

        // Output register must hold while writeback stalls.
        wb_ready = 1'b0;
        ex_valid = 1'b1; ex_mem_ren = 1'b0; ex_mem_wen = 1'b0; ex_alu_result = 32'hAAAA;
        @(posedge clk); #1;
        ex_alu_result = 32'hBBBB;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold.ex_ready", 32'(ex_ready), 32'd0);
            chk("hold.wb_data",  wb_data, 32'hAAAA);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("hold.ex_ready_rel", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("hold.wb_next", wb_data, 32'hBBBB);
        @(posedge clk); #1;

        // Reset while waiting for a response, then a stray response.
        ex_valid = 1'b1; ex_mem_ren = 1'b1; ex_mem_size = 2'd2; ex_alu_result = 32'h4000;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_ren = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstw.req_valid", 32'(mem_req_valid), 32'd0);
        chk("rstw.wb_valid",  32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("rstw.stray_wb",  32'(wb_valid), 32'd0);
        chk("rstw.stray_req", 32'(mem_req_valid), 32'd0);
        chk("rstw.ex_ready",  32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        run_op("rstw.lh", 1, 0, 2'd1, 0, 32'h5002, 32'h0, 32'h8001_7FFF, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            sz   = 2'($urandom_range(0, 2));
            a    = $urandom;
            run_op("rnd", kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), a,
                   $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory-access stage of the RV32 five-stage pipeline. Sits directly downstream of the execute stage and upstream of writeback.
- Consumes the execute result: ALU result used as address, rs2 data as store data, plus pc, inst and the LSU/WBU control fields.
- Issues loads and stores over a simple valid/ready memory bus and produces a registered, sign/zero-extended result for writeback.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
WIDTH, 32, datapath and address width
WB_CTRL_W, 8, width of the opaque writeback control field carried through unchanged

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept (combinational)
ex_alu_result  in  WIDTH  effective address, or the result for non-memory instructions
ex_rs2_data  in  WIDTH  store data
ex_pc  in  WIDTH  instruction pc
ex_inst  in  WIDTH  instruction word
ex_mem_ren  in  1  load
ex_mem_wen  in  1  store (ren and wen are never both 1)
ex_mem_size  in  2  0 = byte, 1 = half, 2 = word
ex_mem_unsigned  in  1  zero-extend load (LBU/LHU)
ex_wb_ctrl  in  WB_CTRL_W  writeback control, passed through
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  1 = write
mem_req_addr  out  WIDTH  word-aligned address
mem_req_wdata  out  WIDTH  lane-replicated store data
mem_req_wstrb  out  4  byte enables
mem_resp_valid  in  1  read data / write ack, single-cycle pulse
mem_resp_rdata  in  WIDTH  read word
wb_valid  out  1  result valid to writeback
wb_ready  in  1  writeback accepts
wb_data  out  WIDTH  load data or pass-through ALU result
wb_pc  out  WIDTH  registered pc
wb_inst  out  WIDTH  registered instruction word
wb_ctrl  out  WB_CTRL_W  registered writeback control
wb_misalign  out  1  access was misaligned and was not issued

Behaviour:
- Reset (rst = 0, asynchronous): state goes to IDLE. wb_valid, wb_misalign and mem_req_valid are 0. wb_data, wb_pc, wb_inst and wb_ctrl are 0.
- States: IDLE, REQ, WAIT.
- Output register: wb_* form a one-entry register. It is released when wb_valid && wb_ready.
- ex_ready = (state == IDLE) && (!wb_valid || wb_ready).
- Accept condition: ex_valid && ex_ready.
  - Non-memory instruction: output register loads {alu_result, pc, inst, wb_ctrl} with wb_valid = 1 on the next edge. Throughput is 1 per cycle.
  - Aligned memory instruction: latch addr, size, unsigned, store data, pc, inst and ctrl. Go to REQ.
  - Misaligned memory instruction: no bus request. Output loads wb_data = 0 and wb_misalign = 1 on the next edge. Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
- REQ:
  - mem_req_valid = 1; request fields stay stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, load the output register with wb_valid = 1 and go to IDLE.
  - Load: wb_data = extracted, extended data.
  - Store: wb_data = the address.
- Request formatting:
  - mem_req_addr = {addr[31:2], 2'b00}.
  - wstrb: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111. Loads drive wstrb = 0.
  - wdata: byte = {4{rs2[7:0]}}; half = {2{rs2[15:0]}}; word = rs2.
- Load extraction: shift rdata right by 8*addr[1:0]. Take the low 8, 16 or 32 bits. Sign-extend unless unsigned.
- Response timing: a response is only accepted in WAIT and arrives at least one cycle after the request handshake. mem_resp_valid in IDLE or REQ is ignored; this covers a stray response after a mid-transaction reset.
- Output stall: the output register is never overwritten while wb_valid && !wb_ready.
- Latency: load/store 2 + bus cycles (1 accept → REQ, handshake → WAIT, response → registered).

Decomposition:
- Shared package holds the size encodings (MEM_B/MEM_H/MEM_W), the state encoding, and the WB_CTRL_W constant, used by both EX and WB.
- One sub-module, lsu_align: combinational; produces wstrb/wdata from (size, addr[1:0], rs2) and load data from (size, unsigned, addr[1:0], rdata). The FSM and registers live in lsu_stage.

Test Plan:
- Non-memory pass-through: alu_result = 0x1234 on three back-to-back instructions, wb_ready = 1 → wb_data 0x1234 one cycle after each accept; ex_ready stays 1.
- LB at addr 0x1003 with rdata 0x80FF_0000 → mem_req_addr 0x1000, wstrb 0; wb_data 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at addr 0x2002 with rs2 0xABCD_1234 → wdata 0x1234_1234, wstrb 4'b1100, wen 1; after ack wb_valid = 1 and wb_data = 0x2002.
- Bus stall: mem_req_ready low for 3 cycles → mem_req_valid, addr, wdata and wstrb held stable; ex_ready = 0 throughout.
- Misaligned LW at 0x3001 → no mem_req_valid; next cycle wb_valid = 1, wb_misalign = 1, wb_data = 0.
- Reset asserted in WAIT, then a mem_resp_valid pulse after release → IDLE, wb_valid stays 0, stray response ignored; the next load completes normally.
